// File: rtl/multich_bessel_filter.sv
// Multi-channel cascaded single-pole low-pass filter with shared runtime coefficient,
// per-sample bypass and sticky per-channel saturation flags.
module multich_bessel_filter #(
  parameter int unsigned ADC_WIDTH  = 14,
  parameter int unsigned NCH        = 2,
  parameter int unsigned ORDER      = 2,
  parameter int unsigned COEF_WIDTH = 18,
  parameter int unsigned FRAC       = 16,
  parameter int unsigned B          = 2158
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  input  logic [NCH*ADC_WIDTH-1:0]  adc_dat,
  input  logic                      bypass,
  input  logic                      coef_wr,
  input  logic [COEF_WIDTH-1:0]     coef_data,
  input  logic                      sat_clr,
  output logic                      out_valid,
  output logic [NCH*ADC_WIDTH-1:0]  adc_filt,
  output logic [NCH-1:0]            sat_flag,
  output logic [COEF_WIDTH-1:0]     coef_active
);

  localparam int unsigned AW  = ADC_WIDTH;
  localparam int unsigned CW  = COEF_WIDTH;
  localparam int unsigned SW  = AW + FRAC + 1;
  localparam int unsigned DW  = SW + 1;
  localparam int unsigned CSW = CW + 1;
  localparam int unsigned PW  = DW + CSW;

  localparam logic signed [AW-1:0] AMAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic signed [AW-1:0] AMIN = {1'b1, {(AW-1){1'b0}}};
  localparam logic signed [PW-1:0] OMAX = PW'(AMAX);
  localparam logic signed [PW-1:0] OMIN = PW'(AMIN);

  // Stage 0 is the input register; stage k (1..ORDER) is the output of section k.
  logic signed [AW-1:0] dat_q  [ORDER+1][NCH];
  logic signed [AW-1:0] dat_d  [ORDER+1][NCH];
  logic [ORDER:0]       vld_q, vld_d;
  logic [ORDER-1:0]     byp_q, byp_d;
  logic [CW-1:0]        coef_q [ORDER];
  logic [CW-1:0]        coef_d [ORDER];
  logic signed [SW-1:0] y_q    [ORDER][NCH];
  logic signed [SW-1:0] y_d    [ORDER][NCH];
  logic [NCH-1:0]       sat_q, sat_d;
  logic [CW-1:0]        shadow_q, shadow_d;

  logic [NCH-1:0]       sat_set;
  logic signed [AW-1:0] sec_x;
  logic signed [PW-1:0] sec_sum;
  logic signed [PW-1:0] sec_out;

  // Full-precision section update: y + (((x << FRAC) - y) * coef) >>> FRAC.
  function automatic logic signed [PW-1:0] section_sum(
    input logic signed [AW-1:0] x,
    input logic signed [SW-1:0] y,
    input logic [CW-1:0]        c
  );
    logic signed [DW-1:0]  d;
    logic signed [CSW-1:0] cs;
    logic signed [PW-1:0]  p;
    d  = (DW'(x) <<< FRAC) - DW'(y);
    cs = $signed({1'b0, c});
    p  = PW'(d) * PW'(cs);
    return (p >>> FRAC) + PW'(y);
  endfunction

  always_comb begin
    shadow_d = coef_wr ? coef_data : shadow_q;
    vld_d    = {vld_q[ORDER-1:0], in_valid};
    byp_d    = byp_q;
    coef_d   = coef_q;
    dat_d    = dat_q;
    y_d      = y_q;
    sat_set  = '0;
    sec_x    = '0;
    sec_sum  = '0;
    sec_out  = '0;

    // The coefficient captured here is the pre-write shadow when coef_wr coincides.
    if (in_valid) begin
      byp_d[0]  = bypass;
      coef_d[0] = shadow_q;
      for (int c = 0; c < NCH; c++) begin
        dat_d[0][c] = adc_dat[c*AW +: AW];
      end
    end

    for (int k = 1; k < ORDER; k++) begin
      if (vld_q[k-1]) begin
        byp_d[k]  = byp_q[k-1];
        coef_d[k] = coef_q[k-1];
      end
    end

    for (int k = 0; k < ORDER; k++) begin
      if (vld_q[k]) begin
        for (int c = 0; c < NCH; c++) begin
          sec_x = dat_q[k][c];
          if (byp_q[k]) begin
            y_d[k][c]     = SW'(sec_x) <<< FRAC;
            dat_d[k+1][c] = sec_x;
          end else begin
            sec_sum = section_sum(sec_x, y_q[k][c], coef_q[k]);
            sec_out = sec_sum >>> FRAC;
            if (sec_out > OMAX) begin
              dat_d[k+1][c] = AMAX;
              y_d[k][c]     = SW'(AMAX) <<< FRAC;
              sat_set[c]    = 1'b1;
            end else if (sec_out < OMIN) begin
              dat_d[k+1][c] = AMIN;
              y_d[k][c]     = SW'(AMIN) <<< FRAC;
              sat_set[c]    = 1'b1;
            end else begin
              dat_d[k+1][c] = AW'(sec_out);
              y_d[k][c]     = SW'(sec_sum);
            end
          end
        end
      end
    end

    sat_d = sat_set | (sat_clr ? '0 : sat_q);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= CW'(B);
      vld_q    <= '0;
      byp_q    <= '0;
      coef_q   <= '{default: CW'(B)};
      dat_q    <= '{default: '0};
      y_q      <= '{default: '0};
      sat_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      vld_q    <= vld_d;
      byp_q    <= byp_d;
      coef_q   <= coef_d;
      dat_q    <= dat_d;
      y_q      <= y_d;
      sat_q    <= sat_d;
    end
  end

  always_comb begin
    adc_filt = '0;
    for (int c = 0; c < NCH; c++) begin
      adc_filt[c*AW +: AW] = dat_q[ORDER][c];
    end
  end

  assign out_valid   = vld_q[ORDER];
  assign sat_flag    = sat_q;
  assign coef_active = coef_q[0];

endmodule

// File: tb/tb_multich_bessel_filter.sv
// Scoreboard bench for multich_bessel_filter: the driver pushes expected lanes and arrival
// cycle per accepted sample; a negedge monitor pops and compares whenever out_valid is high.
module tb_multich_bessel_filter;

  localparam int AW  = 14;
  localparam int NC  = 2;
  localparam int ORD = 2;
  localparam int CW  = 18;
  localparam int FR  = 16;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic [NC*AW-1:0] adc_dat;
  logic             bypass;
  logic             coef_wr;
  logic [CW-1:0]    coef_data;
  logic             sat_clr;
  logic             out_valid;
  logic [NC*AW-1:0] adc_filt;
  logic [NC-1:0]    sat_flag;
  logic [CW-1:0]    coef_active;

  logic             o1_valid;
  logic [NC*AW-1:0] o1_filt;
  logic [NC-1:0]    o1_sat;
  logic [CW-1:0]    o1_coef;

  multich_bessel_filter #(.ADC_WIDTH(AW), .NCH(NC), .ORDER(ORD), .COEF_WIDTH(CW),
                          .FRAC(FR), .B(2158)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .adc_dat(adc_dat), .bypass(bypass),
    .coef_wr(coef_wr), .coef_data(coef_data), .sat_clr(sat_clr), .out_valid(out_valid),
    .adc_filt(adc_filt), .sat_flag(sat_flag), .coef_active(coef_active));

  multich_bessel_filter #(.ADC_WIDTH(AW), .NCH(NC), .ORDER(1), .COEF_WIDTH(CW),
                          .FRAC(FR), .B(2158)) dut_o1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .adc_dat(adc_dat), .bypass(bypass),
    .coef_wr(coef_wr), .coef_data(coef_data), .sat_clr(sat_clr), .out_valid(o1_valid),
    .adc_filt(o1_filt), .sat_flag(o1_sat), .coef_active(o1_coef));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [NC*AW-1:0] dat;
    int               cyc;
  } exp_t;

  exp_t             sb[$];
  exp_t             item;
  longint           my[ORD][NC];
  int unsigned      m_shadow;
  logic [NC*AW-1:0] last_out = '0;

  bit     o1_en = 1'b0;
  int     o1_n = 0;
  int     o1_first_cyc = 0;
  longint o1_prev = 0;
  longint o1_v;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint lane(input logic [NC*AW-1:0] v, input int c);
    logic [AW-1:0] t;
    t = v[c*AW +: AW];
    return longint'($signed(t));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < ORD; k++)
      for (int ch = 0; ch < NC; ch++) my[k][ch] = 0;
    m_shadow = 2158;
  endtask

  // Reference recurrence on 64-bit integers, clamping each section to the 14-bit range.
  task automatic model(input int x0, input int x1, input bit byp, output logic [NC*AW-1:0] e);
    longint v, d, yn;
    e = '0;
    for (int ch = 0; ch < NC; ch++) begin
      v = (ch == 0) ? longint'(x0) : longint'(x1);
      for (int k = 0; k < ORD; k++) begin
        if (byp) begin
          my[k][ch] = v <<< FR;
        end else begin
          d  = (v <<< FR) - my[k][ch];
          yn = my[k][ch] + ((d * longint'(m_shadow)) >>> FR);
          v  = yn >>> FR;
          if (v > 8191) begin
            v  = 8191;
            yn = v <<< FR;
          end else if (v < -8192) begin
            v  = -8192;
            yn = v <<< FR;
          end
          my[k][ch] = yn;
        end
      end
      e[ch*AW +: AW] = AW'(v);
    end
  endtask

  task automatic drive(input bit v, input int x0, input int x1, input bit byp,
                       input bit wr, input int unsigned wd, input bit clr);
    logic [NC*AW-1:0] e;
    @(posedge clk);
    #1;
    in_valid  = v;
    adc_dat   = {AW'(x1), AW'(x0)};
    bypass    = byp;
    coef_wr   = wr;
    coef_data = CW'(wd);
    sat_clr   = clr;
    if (v) begin
      model(x0, x1, byp, e);
      sb.push_back('{dat: e, cyc: cyc + ORD + 1});
    end
    if (wr) m_shadow = wd;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (reset) begin
      last_out = '0;
    end else begin
      if (out_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid actual=%h expected=none (cycle %0d)", adc_filt, cyc);
        end else begin
          item = sb.pop_front();
          chk("filt_data", longint'(adc_filt), longint'(item.dat));
          chk("filt_latency", longint'(cyc), longint'(item.cyc));
        end
        last_out = adc_filt;
      end else begin
        chk("filt_hold", longint'(adc_filt), longint'(last_out));
      end
      if (o1_en && o1_valid) begin
        o1_v = lane(o1_filt, 0);
        if (o1_n == 0) begin
          chk("o1_first_value", o1_v, 263);
          chk("o1_first_latency", longint'(cyc), longint'(o1_first_cyc));
        end else begin
          chk("o1_monotone", longint'(o1_v >= o1_prev), 1);
        end
        if (o1_n == 599) chk("o1_settled", longint'(o1_v >= 7999 && o1_v <= 8001), 1);
        o1_prev = o1_v;
        o1_n++;
      end
    end
  end

  int pat[6] = '{1, 0, 1, 1, 0, 1};

  initial begin
    reset = 1'b1; in_valid = 1'b0; adc_dat = '0; bypass = 1'b0;
    coef_wr = 1'b0; coef_data = '0; sat_clr = 1'b0;
    model_reset();
    #1;
    chk("rst_out_valid", longint'(out_valid), 0);
    chk("rst_adc_filt", longint'(adc_filt), 0);
    chk("rst_sat_flag", longint'(sat_flag), 0);
    chk("rst_coef_active", longint'(coef_active), 2158);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Step 8000 on ch0 from reset; second-order first output is 263 -> 8.
    o1_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      drive(1'b1, 8000, 0, 1'b0, 1'b0, 0, 1'b0);
      if (i == 0) o1_first_cyc = cyc + 2;
      if (i == 3) chk("o2_first_value", lane(adc_filt, 0), 8);
    end
    idle(4);
    o1_en = 1'b0;
    chk("o1_count", longint'(o1_n), 600);
    chk("step_no_sat", longint'(sat_flag), 0);

    // Bypass, then leave bypass with the input held.
    repeat (5) drive(1'b1, -5000, 77, 1'b1, 1'b0, 0, 1'b0);
    repeat (10) drive(1'b1, -5000, 77, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    chk("bypass_exit_ch0", lane(adc_filt, 0), -5000);
    chk("bypass_exit_ch1", lane(adc_filt, 1), 77);

    // Coefficient write alongside a sample.
    repeat (3) drive(1'b1, 1234, -1234, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 1234, -1234, 1'b0, 1'b1, 65536, 1'b0);
    chk("coef_active_t", longint'(coef_active), 2158);
    drive(1'b1, 1234, -1234, 1'b0, 1'b0, 0, 1'b0);
    chk("coef_active_t1", longint'(coef_active), 2158);
    drive(1'b1, 1234, -1234, 1'b0, 1'b0, 0, 1'b0);
    chk("coef_active_t2", longint'(coef_active), 65536);
    drive(1'b1, 1234, -1234, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b1, 1234, -1234, 1'b0, 1'b0, 0, 1'b0);
    chk("unity_coef_ch0", lane(adc_filt, 0), 1234);
    chk("unity_coef_ch1", lane(adc_filt, 1), -1234);
    idle(4);

    // Settle at -8192, write 5 then 131072 (last wins), step to +8191.
    repeat (3) drive(1'b1, -8192, 0, 1'b0, 1'b0, 0, 1'b0);
    idle(1);
    drive(1'b0, 0, 0, 1'b0, 1'b1, 5, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b1, 131072, 1'b0);
    repeat (4) drive(1'b1, 8191, 0, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    chk("clamp_ch0", lane(adc_filt, 0), 8191);
    chk("clamp_ch1", lane(adc_filt, 1), 0);
    chk("clamp_sat", longint'(sat_flag), 1);
    chk("coef_last_write", longint'(coef_active), 131072);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    chk("sat_clr_alone", longint'(sat_flag), 0);
    drive(1'b1, -8192, 0, 1'b0, 1'b0, 0, 1'b0);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b1);
    drive(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0);
    chk("sat_set_over_clr", longint'(sat_flag), 1);
    idle(4);

    // Bubble pattern; latency per sample is checked by the monitor.
    for (int i = 0; i < 6; i++) drive(pat[i] != 0, 100, -100, 1'b0, 1'b0, 0, 1'b0);
    idle(4);

    // Reset with the pipeline full.
    repeat (4) drive(1'b1, 300, -300, 1'b0, 1'b0, 0, 1'b0);
    chk("full_before_reset", longint'(out_valid), 1);
    #1;
    reset = 1'b1;
    sb.delete();
    model_reset();
    #1;
    chk("mid_rst_out_valid", longint'(out_valid), 0);
    chk("mid_rst_adc_filt", longint'(adc_filt), 0);
    chk("mid_rst_sat_flag", longint'(sat_flag), 0);
    chk("mid_rst_coef_active", longint'(coef_active), 2158);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;

    repeat (3) drive(1'b1, 500, -500, 1'b0, 1'b0, 0, 1'b0);
    idle(4);
    chk("post_rst_sat_flag", longint'(sat_flag), 0);
    chk("scoreboard_drained", longint'(sb.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
